// File: rtl/invsqrt_lut_arbiter.sv
// Round-robin arbiter sharing one inverse-sqrt LUT among NUM_REQ requesters; responses tagged with requester id.
// Latency: grant/LUT read combinational, response LUT_LATENCY cycles later; no response backpressure. Optional perf counters: INVSQRT_ARB_PERF_EN.
module invsqrt_lut_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_LENGTH = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int LUT_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arb_en,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_LENGTH-1:0]   req_addr,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             lut_en,
  output logic [ADDR_LENGTH-1:0]           lut_addr,
  input  logic [DATA_WIDTH-1:0]            lut_data,
  output logic                             rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic [DATA_WIDTH-1:0]            rsp_data
`ifdef INVSQRT_ARB_PERF_EN
  ,
  output logic [31:0]                      perf_grant_cnt,
  output logic [NUM_REQ*16-1:0]            perf_stall_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any;

  logic [LUT_LATENCY-1:0] tag_vld;
  logic [ID_W-1:0]        tag_id [LUT_LATENCY];

  // Search upward from the pointer, wrapping; reset and arb_en both suppress the grant.
  always_comb begin
    int j;
    j         = 0;
    req_ready = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
    if (!arb_en || rst) gnt_any = 1'b0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign lut_en   = gnt_any;
  assign lut_addr = gnt_any ? req_addr[gnt_idx*ADDR_LENGTH +: ADDR_LENGTH] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int k = 0; k < LUT_LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_vld[0] <= gnt_any;
      tag_id[0]  <= gnt_idx;
      for (int k = 1; k < LUT_LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  // The tag tail lines up with the LUT's read data; outputs are zeroed when idle or in reset.
  assign rsp_valid = tag_vld[LUT_LATENCY-1] && !rst;
  assign rsp_id    = rsp_valid ? tag_id[LUT_LATENCY-1] : '0;
  assign rsp_data  = rsp_valid ? lut_data : '0;

`ifdef INVSQRT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (gnt_any && perf_grant_cnt != '1) perf_grant_cnt <= perf_grant_cnt + 32'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !req_ready[i] && perf_stall_cnt[i*16 +: 16] != 16'hFFFF)
          perf_stall_cnt[i*16 +: 16] <= perf_stall_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_invsqrt_lut_arbiter.sv
// Randomized scoreboard bench for invsqrt_lut_arbiter with an arithmetic round-robin reference model and a latency-LAT LUT model.
module tb_invsqrt_lut_arbiter;
  localparam int N    = 4;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int MAXC = 2048;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            arb_en = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic            lut_en;
  logic [AW-1:0]   lut_addr;
  logic [DW-1:0]   lut_data = '0;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
`ifdef INVSQRT_ARB_PERF_EN
  logic [31:0]     perf_grant_cnt;
  logic [N*16-1:0] perf_stall_cnt;
`endif

  invsqrt_lut_arbiter #(.NUM_REQ(N), .ADDR_LENGTH(AW), .DATA_WIDTH(DW), .LUT_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .lut_en(lut_en), .lut_addr(lut_addr), .lut_data(lut_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef INVSQRT_ARB_PERF_EN
    , .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            run = 1'b0;
  bit            hist_en [MAXC];
  logic [AW-1:0] hist_addr [MAXC];
  int            ptr_m = 0;
  int            gcnt_m = 0;
  int            stall_m [N];

  function automatic logic [DW-1:0] lut_fn(input logic [AW-1:0] a);
    return (DW'(a) + 32'd1) * 32'h9E3779B1 ^ 32'h5A5A0000;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic en, input logic r);
    int g;
    logic [N-1:0]  exp_rdy;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    cyc++;
    if (cyc >= LAT && hist_en[cyc-LAT]) lut_data = lut_fn(hist_addr[cyc-LAT]);
    else                                lut_data = DW'($urandom);
    rst = r;
    arb_en = en;
    req_valid = v;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
    if (r) begin
      q.delete();
      ptr_m = 0;
      gcnt_m = 0;
      for (int i = 0; i < N; i++) stall_m[i] = 0;
    end
    #1;
    g = (!r && en) ? pick(v, ptr_m) : -1;
    exp_rdy = '0;
    exp_addr = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      exp_addr = req_addr[g*AW +: AW];
    end
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
    end
    n_cmp++;
    if (lut_en !== (g >= 0) || lut_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL lut_rd cyc=%0d got en=%b addr=%h exp en=%b addr=%h", cyc, lut_en, lut_addr, g >= 0, exp_addr);
    end
    hist_en[cyc] = lut_en;
    hist_addr[cyc] = lut_addr;
    if (!r) begin
      for (int i = 0; i < N; i++) if (v[i] && g != i) stall_m[i]++;
      if (g >= 0) begin
        q.push_back('{due: cyc + LAT, id: g, data: lut_fn(exp_addr)});
        ptr_m = (g + 1) % N;
        gcnt_m++;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response, flags missing ones.
  always @(negedge clk) begin
    if (run) begin
      #3;
      if (rst) begin
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0) begin
          n_fail++;
          $display("FAIL rst_rsp cyc=%0d got v=%b id=%0d d=%h exp all zero", cyc, rsp_valid, rsp_id, rsp_data);
        end
      end else if (rsp_valid === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_extra cyc=%0d got id=%0d exp no response", cyc, rsp_id);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.due != cyc || int'(rsp_id) != e.id || rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL rsp cyc=%0d got id=%0d d=%h exp cyc=%0d id=%0d d=%h", cyc, rsp_id, rsp_data, e.due, e.id, e.data);
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_missing cyc=%0d got v=%b exp id=%0d", cyc, rsp_valid, e.id);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) stall_m[i] = 0;
    run = 1'b1;
    step('0, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b0100, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b1010, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++)
      step(N'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 60) == 0);
    for (int i = 0; i < LAT + 3; i++) step('0, 1'b1, 1'b0);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got pending=%0d exp 0", q.size());
    end
`ifdef INVSQRT_ARB_PERF_EN
    n_cmp++;
    if (perf_grant_cnt !== 32'(gcnt_m)) begin
      n_fail++;
      $display("FAIL perf_grant got=%0d exp=%0d", perf_grant_cnt, gcnt_m);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (perf_stall_cnt[i*16 +: 16] !== 16'(stall_m[i])) begin
        n_fail++;
        $display("FAIL perf_stall%0d got=%0d exp=%0d", i, perf_stall_cnt[i*16 +: 16], stall_m[i]);
      end
    end
`endif
    run = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
